// File: rtl/arbitro_rr.sv
// arbitro_rr: virtual-channel arbiter for the transmit path.
// Each cycle it picks at most one non-empty VC head (strict priority or
// round-robin), pops it combinationally, and registers the word onto the
// destination port selected by its destination field. Words whose
// destination field is out of range are popped and counted as drops.
module arbitro_rr #(
    parameter int WIDTH    = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2,
    parameter int DEST_LSB = 4,
    parameter int RR_MODE  = 0,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [NUM_VC*WIDTH-1:0]   vc_data,
    input  logic [NUM_VC-1:0]         vc_empty,
    input  logic [NUM_DEST-1:0]       d_pause,
    output logic [NUM_VC-1:0]         vc_pop,
    output logic [NUM_DEST*WIDTH-1:0] d_data,
    output logic [NUM_DEST-1:0]       d_push,
    output logic [NUM_VC*CNT_W-1:0]   grant_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int DEST_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int VC_W   = $clog2(NUM_VC);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    // After reset the pointer sits on the last VC so VC0 has the first turn.
    localparam logic [VC_W-1:0]  LAST_INIT = VC_W'(NUM_VC - 1);

    logic [DEST_W-1:0] head_dest [NUM_VC];
    logic [NUM_VC-1:0] head_legal;
    logic [NUM_VC-1:0] eligible;

    logic              found;
    logic [VC_W-1:0]   winner;
    int                idx;
    logic [VC_W-1:0]   last_grant;
    logic              grant;

    logic [WIDTH-1:0]  win_word;
    logic [DEST_W-1:0] win_dest;
    logic              win_legal;

    // Decode each head's destination and decide whether it may be granted now.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            head_dest[i]  = vc_data[i*WIDTH+DEST_LSB +: DEST_W];
            head_legal[i] = (int'(head_dest[i]) < NUM_DEST);
            // A paused destination only blocks heads aimed at it; drops never wait.
            eligible[i]   = !vc_empty[i] && (!head_legal[i] || !d_pause[head_dest[i]]);
        end
    end

    // Search for the winner: from VC0 in strict mode, from last_grant+1 in round-robin.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (RR_MODE != 0) idx = (int'(last_grant) + 1 + k) % NUM_VC;
            else              idx = k;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = VC_W'(idx);
            end
        end
    end

    // Drive the pop strobe and pick out the winning word; pop is held off during reset.
    always_comb begin
        vc_pop    = '0;
        grant     = reset_L && found;
        win_word  = vc_data[int'(winner)*WIDTH +: WIDTH];
        win_dest  = win_word[DEST_LSB +: DEST_W];
        win_legal = head_legal[winner];
        if (grant) vc_pop[winner] = 1'b1;
    end

    // Register the forwarded word, update the round-robin pointer and the counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_L) begin
            d_data     <= '0;
            d_push     <= '0;
            grant_cnt  <= '0;
            drop_cnt   <= '0;
            last_grant <= LAST_INIT;
        end else begin
            d_push <= '0;
            if (grant) begin
                last_grant <= winner;
                if (win_legal) begin
                    d_data[int'(win_dest)*WIDTH +: WIDTH] <= win_word;
                    d_push[win_dest]                       <= 1'b1;
                end else if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + CNT_ONE;
                end
            end
            for (int i = 0; i < NUM_VC; i++) begin
                if (vc_pop[i] && grant_cnt[i*CNT_W +: CNT_W] != CNT_MAX)
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_ONE;
            end
        end
    end

endmodule
